// File: rtl/packet_frame_writer_if.sv
// FIFO read side, frame-buffer write port and display-bank status of the packet frame writer.
interface packet_frame_writer_if #(
  parameter int H_BITS  = 8,
  parameter int V_BITS  = 8,
  parameter int COLOR_W = 12
);
  logic                     fifo_empty;
  logic                     fifo_re;
  logic [31:0]              fifo_dout;
  logic [1:0]               fifo_type;
  logic                     frame_start;
  logic                     fb_we;
  logic [H_BITS+V_BITS:0]   fb_addr;
  logic [COLOR_W-1:0]       fb_data;
  logic                     disp_bank;
  logic                     busy;
  logic [15:0]              drop_cnt;

  modport master (
    input  fifo_empty, fifo_dout, fifo_type, frame_start,
    output fifo_re, fb_we, fb_addr, fb_data, disp_bank, busy, drop_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_type, frame_start,
    input  fifo_re, fb_we, fb_addr, fb_data, disp_bank, busy, drop_cnt
  );
endinterface

// File: rtl/packet_frame_writer.sv
// Packet-driven write engine: decodes FIFO packets into pixel, span and clear writes
// to the back bank of a double-buffered frame buffer, and swaps banks on frame start.
module packet_frame_writer #(
  parameter int H_BITS  = 8,
  parameter int V_BITS  = 8,
  parameter int H_PIX   = 256,
  parameter int V_PIX   = 192,
  parameter int COLOR_W = 12,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  packet_frame_writer_if.master bus
);

  localparam int FRAME   = H_PIX * V_PIX;
  localparam int FRAME_W = $clog2(FRAME + 1);
  localparam int CNT_W   = (LEN_W > FRAME_W) ? LEN_W : FRAME_W;
  localparam logic [H_BITS-1:0] H_MAX = H_BITS'(H_PIX - 1);
  localparam logic [V_BITS-1:0] V_MAX = V_BITS'(V_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SPAN_WAIT, S_SPAN_LEN, S_FILL, S_SWAP_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [H_BITS-1:0]    h_q, h_d;
  logic [V_BITS-1:0]    v_q, v_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 discard_q, discard_d;
  logic                 swap_pending_q, swap_pending_d;
  logic                 disp_bank_q, disp_bank_d;
  logic [15:0]          drop_q, drop_d;
  logic                 fb_we_q, fb_we_d;
  logic [H_BITS+V_BITS:0] fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_data_q, fb_data_d;

  logic [V_BITS-1:0]    pkt_v;
  logic [H_BITS-1:0]    pkt_h;
  logic [COLOR_W-1:0]   pkt_color;
  logic                 pkt_oor;
  logic [15:0]          drop_inc;

  assign pkt_v     = bus.fifo_dout[31 -: V_BITS];
  assign pkt_h     = bus.fifo_dout[31-V_BITS -: H_BITS];
  assign pkt_color = bus.fifo_dout[COLOR_W-1:0];
  assign pkt_oor   = (32'(pkt_h) >= 32'(H_PIX)) || (32'(pkt_v) >= 32'(V_PIX));
  assign drop_inc  = (drop_q == '1) ? drop_q : drop_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      h_q            <= '0;
      v_q            <= '0;
      color_q        <= '0;
      cnt_q          <= '0;
      discard_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      disp_bank_q    <= 1'b0;
      drop_q         <= '0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      v_q            <= v_d;
      color_q        <= color_d;
      cnt_q          <= cnt_d;
      discard_q      <= discard_d;
      swap_pending_q <= swap_pending_d;
      disp_bank_q    <= disp_bank_d;
      drop_q         <= drop_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_q      <= fb_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    v_d            = v_q;
    color_d        = color_q;
    cnt_d          = cnt_q;
    discard_d      = discard_q;
    swap_pending_d = swap_pending_q;
    disp_bank_d    = disp_bank_q;
    drop_d         = drop_q;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_data_d      = fb_data_q;
    unique case (state_q)
      S_IDLE: if (!bus.fifo_empty) state_d = S_FETCH;
      S_FETCH: begin
        unique case (bus.fifo_type)
          2'd0: begin
            state_d = S_IDLE;
            if (pkt_oor) begin
              drop_d = drop_inc;
            end else begin
              fb_we_d   = 1'b1;
              fb_addr_d = {~disp_bank_q, pkt_h, pkt_v};
              fb_data_d = pkt_color;
            end
          end
          2'd1: begin
            // An out-of-range span still owns the next FIFO word; it is consumed and discarded.
            h_d       = pkt_h;
            v_d       = pkt_v;
            color_d   = pkt_color;
            discard_d = pkt_oor;
            if (pkt_oor) drop_d = drop_inc;
            state_d   = S_SPAN_WAIT;
          end
          2'd2: begin
            color_d = pkt_color;
            h_d     = '0;
            v_d     = '0;
            cnt_d   = CNT_W'(FRAME);
            state_d = S_FILL;
          end
          default: begin
            swap_pending_d = 1'b1;
            state_d        = S_SWAP_WAIT;
          end
        endcase
      end
      S_SPAN_WAIT: if (!bus.fifo_empty) state_d = S_SPAN_LEN;
      S_SPAN_LEN: begin
        cnt_d   = CNT_W'(bus.fifo_dout[LEN_W-1:0]);
        state_d = (cnt_d == '0 || discard_q) ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        fb_we_d   = 1'b1;
        fb_addr_d = {~disp_bank_q, h_q, v_q};
        fb_data_d = color_q;
        cnt_d     = cnt_q - CNT_W'(1);
        if (h_q == H_MAX) begin
          h_d = '0;
          v_d = (v_q == V_MAX) ? '0 : v_q + V_BITS'(1);
        end else begin
          h_d = h_q + H_BITS'(1);
        end
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      S_SWAP_WAIT: begin
        if (bus.frame_start && swap_pending_q) begin
          disp_bank_d    = ~disp_bank_q;
          swap_pending_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.fifo_re = 1'b0;
    if (!reset && !bus.fifo_empty && (state_q == S_IDLE || state_q == S_SPAN_WAIT))
      bus.fifo_re = 1'b1;
    bus.busy      = (state_q != S_IDLE);
    bus.fb_we     = fb_we_q;
    bus.fb_addr   = fb_addr_q;
    bus.fb_data   = fb_data_q;
    bus.disp_bank = disp_bank_q;
    bus.drop_cnt  = drop_q;
  end

endmodule

// File: doc/packet_frame_writer.md
Name: packet_frame_writer

Overview:
- Packet-driven frame-buffer write engine; successor to the single-pixel ray-tracer controller.
- Pops 32-bit packets from the SPI receive FIFO and issues write-port traffic to a double-banked frame buffer.
- Packet types: single pixel, horizontal span with row wrap, full-frame clear, and a buffer swap synchronised to display frame start.
- Sits between the SPI interface (FIFO read side) and the frame buffer RTU write port, on the 75 MHz pixel clock.

Parameters:
- H_BITS, 8, width of horizontal pixel coordinate.
- V_BITS, 8, width of vertical pixel coordinate.
- H_PIX, 256, visible columns; legal h is 0..H_PIX-1, and H_PIX <= 2^H_BITS.
- V_PIX, 192, visible rows; legal v is 0..V_PIX-1, and V_PIX <= 2^V_BITS.
- COLOR_W, 12, pixel color width; requires V_BITS+H_BITS+COLOR_W <= 32.
- LEN_W, 16, span length width.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  receive FIFO empty.
- fifo_re  out  1  FIFO read enable; data is valid the cycle after.
- fifo_dout  in  32  packet word: [31 -: V_BITS]=v, next H_BITS=h, [COLOR_W-1:0]=color.
- fifo_type  in  2  packet type; valid with fifo_dout. 0=PIXEL, 1=SPAN, 2=CLEAR, 3=SWAP.
- frame_start  in  1  one-cycle pulse from display at start of vertical blank.
- fb_we  out  1  frame-buffer write enable (registered).
- fb_addr  out  1+H_BITS+V_BITS  {bank, h, v} (registered).
- fb_data  out  COLOR_W  write color (registered).
- disp_bank  out  1  bank the display reads; writes always target ~disp_bank.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  16  count of dropped out-of-range PIXEL/SPAN packets; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0.
  - fifo_re=0, disp_bank=0, busy=0, drop_cnt=0.
  - FSM enters IDLE and any pending swap is cleared.
- Reset mid-operation aborts any span, clear or swap immediately. No further fb_we after the reset cycle.
- fifo_re is combinational. It is asserted only in IDLE or SPAN_WAIT, and only when !fifo_empty. It is never asserted when empty.
- FSM states and transitions:
  - IDLE: if !fifo_empty, assert fifo_re and go to FETCH.
  - FETCH: decode fifo_type/fifo_dout.
    - PIXEL, in range: register fb_we=1, addr={~disp_bank,h,v}, data=color; go to IDLE. The write is visible the cycle after FETCH, so latency from fifo_re to fb_we is 2 cycles and throughput is one pixel per 2 cycles.
    - PIXEL, h>=H_PIX or v>=V_PIX: no write, drop_cnt+1, go to IDLE.
    - SPAN: latch h, v, color. If start is out of range, drop (drop_cnt+1) and consume the length word anyway via SPAN_WAIT with a discard flag. Otherwise go to SPAN_WAIT.
    - CLEAR: latch color, set h=0, v=0, go to FILL with count=H_PIX*V_PIX.
    - SWAP: set swap_pending and go to SWAP_WAIT.
  - SPAN_WAIT: wait while fifo_empty. When !fifo_empty, assert fifo_re and go to SPAN_LEN.
  - SPAN_LEN: count = fifo_dout[LEN_W-1:0], ignoring fifo_type.
    - count=0 or discard flag set: go to IDLE with no writes.
    - Otherwise go to FILL.
  - FILL: one write per cycle to {~disp_bank,h,v} with the latched color; count-1 each cycle; exit to IDLE after the last write.
    - h increments. At h=H_PIX-1, h wraps to 0 and v+1.
    - At v=V_PIX-1 with h=H_PIX-1, both wrap to 0.
  - SWAP_WAIT: no FIFO reads and no writes. On frame_start: disp_bank toggles, swap_pending clears, go to IDLE.
- frame_start pulses outside SWAP_WAIT are ignored.
- A frame_start in the same cycle as the FETCH of a SWAP is not honoured; the swap waits for the next pulse.
- Counter widths:
  - FILL count is wide enough for H_PIX*V_PIX (>= 16 bits for the defaults, 49152).
  - Span lengths larger than the frame wrap and overwrite; no clamping.

Test Plan:
- reset, then PIXEL {v=5,h=10,color=0xABC} with FIFO non-empty -> fifo_re cycle 0; fb_we=1 on cycle 2 only, addr={1,0x0A,0x05}, data=0xABC; busy drops cycle 2.
- PIXEL h=200, v=192 (V_PIX=192) -> no fb_we; drop_cnt=1.
- SPAN h=254,v=3,color=0x0F0, then FIFO empty for 5 cycles, then length=4 -> no FIFO reads while waiting. After SPAN_LEN, 4 consecutive writes at (254,3),(255,3),(0,4),(1,4), then IDLE.
- SPAN with length=0 -> zero writes; the next packet is still consumed normally.
- CLEAR color=0x000 -> exactly 49152 consecutive fb_we cycles, first (0,0), last (255,191), bank=1.
- SWAP, frame_start 10 cycles later -> disp_bank 0->1 the cycle after the pulse, no fifo_re during the wait. A following PIXEL then writes with bank bit 0. Assert reset during a CLEAR: fb_we=0 the next cycle and disp_bank=0.
